// File: rtl/yutorina_spm_arb.sv
// Two-requester arbiter (m0 = CPU data path, m1 = DMA) for the SPM data port; one access per 3 cycles.
// Define SPM_ARB_RR_EN for round-robin tie-break; default build is fixed priority with m0 winning ties.
module yutorina_spm_arb #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_gnt,
    output logic              m0_rdy,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_gnt,
    output logic              m1_rdy,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    // Handshake: a requester holds req and its attributes until its one-cycle rdy pulse; gnt is
    // high from the cycle after the grant edge through the rdy cycle. Attributes are latched at
    // the grant edge, so dropping req early still completes the access.
    localparam logic READ     = 1'b1;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_next;
    logic              grant;
    logic              winner;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              strobe;
    logic              done;

`ifdef SPM_ARB_RR_EN
    logic last_q;

    always_comb begin
        winner = m1_req;
        if (m0_req && m1_req) winner = ~last_q;
    end

    always_ff @(posedge clk) begin
        if (reset)      last_q <= 1'b0;
        else if (grant) last_q <= winner;
    end
`else
    always_comb winner = ~m0_req;
`endif

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            rw_q      <= READ;
            wr_data_q <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner_q   <= winner;
                addr_q    <= winner ? m1_addr    : m0_addr;
                rw_q      <= winner ? m1_rw      : m0_rw;
                wr_data_q <= winner ? m1_wr_data : m0_wr_data;
            end
        end
    end

    // Reset is qualified in combinationally so a reset cycle landing on ACCESS or DONE
    // neither strobes the SPM nor signals completion.
    always_comb begin
        strobe      = (state == ACCESS) && !reset;
        done        = (state == DONE) && !reset;
        spm_as_     = strobe ? ENABLE_ : DISABLE_;
        spm_rw      = strobe ? rw_q : READ;
        spm_addr    = strobe ? addr_q : '0;
        spm_wr_data = strobe ? wr_data_q : '0;
        m0_gnt      = (state != IDLE) && !owner_q;
        m1_gnt      = (state != IDLE) && owner_q;
        m0_rdy      = done && !owner_q;
        m1_rdy      = done && owner_q;
        m0_rd_data  = m0_rdy ? spm_rd_data : '0;
        m1_rd_data  = m1_rdy ? spm_rd_data : '0;
    end

endmodule

// File: tb/tb_yutorina_spm_arb.sv
// Bench for yutorina_spm_arb: SPM memory model, transaction-level reference model checked every
// cycle, and directed scenarios with literal expectations (build with SPM_ARB_RR_EN for round-robin).
module tb_yutorina_spm_arb;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_rw = RD;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wr_data = '0;
    logic          m1_req = 1'b0, m1_rw = RD;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wr_data = '0;
    logic          m0_gnt, m0_rdy, m1_gnt, m1_rdy;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic [AW-1:0] spm_addr;
    logic          spm_as_, spm_rw;
    logic [DW-1:0] spm_wr_data;
    logic [DW-1:0] spm_rd_data = '0;

    int checks = 0;
    int errors = 0;

    yutorina_spm_arb dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wr_data(m0_wr_data),
        .m0_gnt(m0_gnt), .m0_rdy(m0_rdy), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wr_data(m1_wr_data),
        .m1_gnt(m1_gnt), .m1_rdy(m1_rdy), .m1_rd_data(m1_rd_data),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    // ---------------- clock / timeout ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // ---------------- SPM memory model (data one cycle after strobe) ----------------
    logic [DW-1:0] spm_mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) spm_mem[i] = '0;
        spm_mem[12'h010] = 32'hDEADBEEF;
        spm_mem[12'h020] = 32'h11112222;
        forever begin
            @(posedge clk);
            if (spm_as_ == 1'b0) begin
                spm_rd_data = spm_mem[spm_addr];
                if (spm_rw == WR) spm_mem[spm_addr] = spm_wr_data;
            end
        end
    end

    // ---------------- reference model: transactions by age since grant ----------------
    logic [DW-1:0] ref_mem [4096];
    bit            model_ok = 0, t_active = 0, t_owner = 0, t_rw = 1'b1, rr_last = 0, m_win;
    int            t_age = 0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_data = '0, t_rdval = '0;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        ref_mem[12'h010] = 32'hDEADBEEF;
        ref_mem[12'h020] = 32'h11112222;
        forever begin
            @(posedge clk);
            if (reset) begin
                t_active = 0;
                rr_last  = 0;
                model_ok = 1;
            end else begin
                if (t_active && t_age == 1) begin
                    t_rdval = ref_mem[t_addr];
                    if (t_rw == WR) ref_mem[t_addr] = t_data;
                end
                if (t_active) begin
                    t_age++;
                    if (t_age > 2) t_active = 0;
                end else if (m0_req || m1_req) begin
`ifdef SPM_ARB_RR_EN
                    if (m0_req && m1_req) m_win = (rr_last == 0);
                    else                  m_win = m1_req;
`else
                    m_win = m0_req ? 1'b0 : 1'b1;
`endif
                    rr_last  = m_win;
                    t_active = 1;
                    t_age    = 1;
                    t_owner  = m_win;
                    t_addr   = m_win ? m1_addr : m0_addr;
                    t_rw     = m_win ? m1_rw : m0_rw;
                    t_data   = m_win ? m1_wr_data : m0_wr_data;
                end
            end
        end
    end

    // ---------------- per-cycle compare against model ----------------
    bit c_strobe, c_done;
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                c_strobe = t_active && t_age == 1 && !reset;
                c_done   = t_active && t_age == 2 && !reset;
                check("m0_gnt", m0_gnt, t_active && !t_owner);
                check("m1_gnt", m1_gnt, t_active && t_owner);
                check("gnt_exclusive", m0_gnt & m1_gnt, 0);
                check("spm_as_", spm_as_, !c_strobe);
                check("spm_rw", spm_rw, c_strobe ? t_rw : RD);
                check("spm_addr", spm_addr, c_strobe ? t_addr : '0);
                check("spm_wr_data", spm_wr_data, c_strobe ? t_data : '0);
                check("m0_rdy", m0_rdy, c_done && !t_owner);
                check("m1_rdy", m1_rdy, c_done && t_owner);
                check("m0_rd_data", m0_rd_data, (c_done && !t_owner) ? t_rdval : '0);
                check("m1_rd_data", m1_rd_data, (c_done && t_owner) ? t_rdval : '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit req, input logic [AW-1:0] a, input bit rw,
                         input logic [DW-1:0] d);
        if (!m) begin
            m0_req = req; m0_addr = a; m0_rw = rw; m0_wr_data = d;
        end else begin
            m1_req = req; m1_addr = a; m1_rw = rw; m1_wr_data = d;
        end
    endtask

    task automatic wait_rdy(input bit m, output logic [DW-1:0] rd);
        int n;
        n = 0;
        rd = '0;
        forever begin
            @(negedge clk);
            if ((m ? m1_rdy : m0_rdy) === 1'b1) begin
                rd = m ? m1_rd_data : m0_rd_data;
                break;
            end
            n++;
            if (n > 20) begin
                check("rdy_timeout", m ? m1_rdy : m0_rdy, 1);
                break;
            end
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the cycle after rdy with req dropped.
    task automatic txn(input bit m, input logic [AW-1:0] a, input bit rw, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd);
        drive(m, 1, a, rw, d);
        wait_rdy(m, rd);
        step();
        drive(m, 0, '0, RD, '0);
    endtask

    // ---------------- directed scenarios ----------------
    logic [0:0]    exp_q[$];
    logic [DW-1:0] rd;
    logic [0:0]    got;
    int            n_done, cyc, n_rdy, n_as, n_busy;

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_as_", spm_as_, 1);
        check("reset_rw", spm_rw, RD);
        check("reset_gnt", {m0_gnt, m1_gnt, m0_rdy, m1_rdy}, 4'b0000);
        step();

        // single read: strobe 1 cycle after req, rdy 2 cycles after
        drive(0, 1, 12'h010, RD, '0);
        @(negedge clk);
        check("rd_as_req_cycle", spm_as_, 1);
        @(negedge clk);
        check("rd_as_k1", spm_as_, 0);
        check("rd_addr_k1", spm_addr, 12'h010);
        check("rd_gnt_k1", m0_gnt, 1);
        @(negedge clk);
        check("rd_rdy_k2", m0_rdy, 1);
        check("rd_data_k2", m0_rd_data, 32'hDEADBEEF);
        step();
        drive(0, 0, '0, RD, '0);
        @(negedge clk);
        check("rd_rdy_after", m0_rdy, 0);
        check("rd_data_after", m0_rd_data, 0);
        step();

        // m1 write then read of 0x3FF
        drive(1, 1, 12'h3FF, WR, 32'h12345678);
        @(negedge clk);
        check("wr_rw_req_cycle", spm_rw, RD);
        @(negedge clk);
        check("wr_rw_access", spm_rw, WR);
        check("wr_data_access", spm_wr_data, 32'h12345678);
        @(negedge clk);
        check("wr_rdy", m1_rdy, 1);
        check("wr_rw_done", spm_rw, RD);
        step();
        drive(1, 0, '0, RD, '0);
        step();
        txn(1, 12'h3FF, RD, '0, rd);
        check("wr_then_rd", rd, 32'h12345678);

        // tie: both request continuously for four transactions
`ifdef SPM_ARB_RR_EN
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`endif
        drive(0, 1, 12'h010, RD, '0);
        drive(1, 1, 12'h3FF, RD, '0);
        n_done = 0;
        cyc = 0;
        while (n_done < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m0_rdy || m1_rdy) begin
                got = m1_rdy;
                check("tie_order", got, exp_q.pop_front());
                n_done++;
            end
        end
        check("tie_count", n_done, 4);
        step();
        drive(0, 0, '0, RD, '0);
        drive(1, 0, '0, RD, '0);
        step();

        // reset during a write's ACCESS cycle aborts it
        drive(0, 1, 12'h020, WR, 32'hCAFEF00D);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rstwr_as_", spm_as_, 1);
        check("rstwr_rdy", m0_rdy, 0);
        step();
        reset = 1'b0;
        drive(0, 0, '0, RD, '0);
        @(negedge clk);
        check("rstwr_after_gnt", m0_gnt, 0);
        check("rstwr_after_rdy", m0_rdy, 0);
        check("rstwr_after_as_", spm_as_, 1);
        check("rstwr_after_addr", spm_addr, 0);
        step();
        txn(0, 12'h020, RD, '0, rd);
        check("rstwr_old_value", rd, 32'h11112222);

        // m1 drops req the cycle after grant
        drive(1, 1, 12'h3FF, RD, '0);
        step();
        drive(1, 0, '0, RD, '0);
        n_rdy = 0;
        rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m1_rdy) begin
                n_rdy++;
                rd = m1_rd_data;
            end
        end
        check("drop_rdy_count", n_rdy, 1);
        check("drop_rd_data", rd, 32'h12345678);
        check("drop_idle_gnt", m1_gnt, 0);
        step();

        // idle for 20 cycles
        n_as = 0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spm_as_ == 1'b0) n_as++;
            if (m0_gnt || m1_gnt || m0_rdy || m1_rdy) n_busy++;
        end
        check("idle_as_low_cycles", n_as, 0);
        check("idle_busy_cycles", n_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
